// File: rtl/muldiv_sched.sv
// muldiv_sched: shares one multi-cycle mul/div unit between execute slots.
// Define MULDIV_RR_EN for round-robin priority; otherwise lowest slot wins.
module muldiv_sched #(
   parameter int REQ_NUM     = 2,
   parameter int TAG_W       = 6,
   parameter int MULT_CYCLES = 3,
   parameter int DIV_CYCLES  = 33
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [REQ_NUM-1:0]               req_valid,
   input  logic [REQ_NUM-1:0]               req_is_div,
   input  logic [REQ_NUM-1:0][TAG_W-1:0]    req_tag,
   output logic [REQ_NUM-1:0]               req_ready,
   output logic                             unit_start,
   output logic                             unit_is_div,
   output logic [$clog2(REQ_NUM)-1:0]       unit_sel,
   output logic                             done_valid,
   output logic [TAG_W-1:0]                 done_tag,
   input  logic                             done_ack,
   input  logic                             flush,
   output logic                             busy
);
   localparam int PTR_W   = $clog2(REQ_NUM);
   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [PTR_W:0] REQ_N = (PTR_W+1)'(REQ_NUM);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [PTR_W-1:0]   base, gnt_idx, idx;
   logic [PTR_W:0]     sum;
   logic               found, accept, grant;

`ifdef MULDIV_RR_EN
   logic [PTR_W-1:0]   rr_q, rr_d;
   logic [PTR_W:0]     nxt;

   assign base = rr_q;

   always_comb begin
      nxt = {1'b0, gnt_idx} + (PTR_W+1)'(1);
      if (nxt >= REQ_N) nxt = '0;
      rr_d = grant ? nxt[PTR_W-1:0] : rr_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rr_q <= '0;
      else         rr_q <= rr_d;
   end
`else
   assign base = '0;
`endif

   // Reset gates the grant so every output reads zero while resetn is low
   assign accept = resetn && !flush &&
                   (state_q == IDLE || (state_q == DONE && done_ack));

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         sum = {1'b0, base} + (PTR_W+1)'(k);
         if (sum >= REQ_N) sum = sum - REQ_N;
         idx = sum[PTR_W-1:0];
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign grant = accept && found;

   always_comb begin
      req_ready   = '0;
      unit_sel    = '0;
      unit_is_div = 1'b0;
      if (grant) begin
         req_ready[gnt_idx] = 1'b1;
         unit_sel           = gnt_idx;
         unit_is_div        = req_is_div[gnt_idx];
      end
   end

   assign unit_start = grant;
   assign done_valid = (state_q == DONE) && !flush;
   assign done_tag   = tag_q;
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      unique case (state_q)
         IDLE: state_d = IDLE;
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DONE;
         end
         DONE: if (done_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (grant) begin
         state_d = RUN;
         tag_d   = req_tag[gnt_idx];
         cnt_d   = req_is_div[gnt_idx] ? CNT_W'(DIV_CYCLES - 1)
                                       : CNT_W'(MULT_CYCLES - 1);
      end
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
      end
   end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed scenarios plus randomized traffic against
// a cycle-time reference model of the shared mul/div scheduler.
module tb_muldiv_sched;
   localparam int MC = 3;
   localparam int DC = 33;
`ifdef MULDIV_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic             clk;
   logic             resetn;
   logic [1:0]       req_valid;
   logic [1:0]       req_is_div;
   logic [1:0][5:0]  req_tag;
   logic [1:0]       req_ready;
   logic             unit_start;
   logic             unit_is_div;
   logic [0:0]       unit_sel;
   logic             done_valid;
   logic [5:0]       done_tag;
   logic             done_ack;
   logic             flush;
   logic             busy;

   int total = 0;
   int bad   = 0;

   muldiv_sched #(
      .REQ_NUM(2), .TAG_W(6), .MULT_CYCLES(MC), .DIV_CYCLES(DC)
   ) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_is_div(req_is_div), .req_tag(req_tag),
      .req_ready(req_ready), .unit_start(unit_start),
      .unit_is_div(unit_is_div), .unit_sel(unit_sel),
      .done_valid(done_valid), .done_tag(done_tag),
      .done_ack(done_ack), .flush(flush), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [1:0] v, input logic [1:0] d,
                        input logic [5:0] t0, input logic [5:0] t1,
                        input logic ack, input logic fl);
      req_valid  = v;
      req_is_div = d;
      req_tag[0] = t0;
      req_tag[1] = t1;
      done_ack   = ack;
      flush      = fl;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      drive(2'b11, 2'b11, 6'd1, 6'd2, 1'b0, 1'b0);
      total++;
      if ({req_ready, unit_start, unit_sel, unit_is_div, done_valid,
           done_tag, busy} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0",
                  {req_ready, unit_start, unit_sel, unit_is_div,
                   done_valid, done_tag, busy});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      resetn = 1'b1;
      tick;
      total++;
      if ({busy, done_valid, unit_start} !== 3'b000) begin
         bad++;
         $display("FAIL reset_idle: got %b want 000",
                  {busy, done_valid, unit_start});
      end
   endtask

   task automatic test_single_mult;
      drive(2'b01, 2'b00, 6'd5, 6'd0, 1'b0, 1'b0);
      total++;
      if ({req_ready, unit_start, unit_sel, unit_is_div} !== 5'b01100) begin
         bad++;
         $display("FAIL mult_grant: got %b want 01100",
                  {req_ready, unit_start, unit_sel, unit_is_div});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      for (int k = 1; k < MC; k++) begin
         total++;
         if ({done_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL mult_run c%0d: got %b want 01", k,
                     {done_valid, busy});
         end
         tick;
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
      total++;
      if ({done_valid, done_tag} !== {1'b1, 6'd5}) begin
         bad++;
         $display("FAIL mult_done: got %b/%0d want 1/5", done_valid, done_tag);
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      total++;
      if ({busy, done_valid} !== 2'b00) begin
         bad++;
         $display("FAIL mult_idle: got %b want 00", {busy, done_valid});
      end
   endtask

   task automatic test_single_div;
      drive(2'b10, 2'b10, 6'd0, 6'd9, 1'b0, 1'b0);
      total++;
      if ({req_ready, unit_start, unit_sel, unit_is_div} !== 5'b10111) begin
         bad++;
         $display("FAIL div_grant: got %b want 10111",
                  {req_ready, unit_start, unit_sel, unit_is_div});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      for (int c = 1; c < DC; c++) begin
         total++;
         if ({done_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL div_run c%0d: got %b want 01", c,
                     {done_valid, busy});
         end
         tick;
      end
      for (int c = DC; c < 40; c++) begin
         total++;
         if ({done_valid, done_tag, busy} !== {1'b1, 6'd9, 1'b1}) begin
            bad++;
            $display("FAIL div_hold c%0d: got %b/%0d want 1/9", c,
                     done_valid, done_tag);
         end
         tick;
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL div_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_contention;
      logic       exp_start, exp_dv, exp_sel, prv_sel;
      logic [5:0] exp_tag;
      for (int c = 0; c <= 12; c++) begin
         drive((c < 12) ? 2'b11 : 2'b00, 2'b00, 6'(10 + c), 6'(40 + c),
               1'b1, 1'b0);
         exp_start = (c % 3 == 0) && (c < 12);
         exp_dv    = (c % 3 == 0) && (c > 0);
         exp_sel   = RR ? 1'((c / 3) % 2) : 1'b0;
         total++;
         if ({unit_start, done_valid} !== {exp_start, exp_dv}) begin
            bad++;
            $display("FAIL cont_ctl c%0d: got %b want %b", c,
                     {unit_start, done_valid}, {exp_start, exp_dv});
         end
         if (exp_start) begin
            total++;
            if (unit_sel !== exp_sel || req_ready !== (2'b01 << exp_sel)) begin
               bad++;
               $display("FAIL cont_sel c%0d: got %0d/%b want %0d", c,
                        unit_sel, req_ready, exp_sel);
            end
         end
         if (exp_dv) begin
            prv_sel = RR ? 1'((c / 3 - 1) % 2) : 1'b0;
            exp_tag = prv_sel ? 6'(40 + c - 3) : 6'(10 + c - 3);
            total++;
            if (done_tag !== exp_tag) begin
               bad++;
               $display("FAIL cont_tag c%0d: got %0d want %0d", c,
                        done_tag, exp_tag);
            end
         end
         tick;
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL cont_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_back_to_back;
      drive(2'b01, 2'b00, 6'd12, 6'd20, 1'b0, 1'b0);
      total++;
      if ({req_ready, unit_start} !== 3'b011) begin
         bad++;
         $display("FAIL b2b_first: got %b want 011", {req_ready, unit_start});
      end
      tick;
      drive(2'b10, 2'b00, 6'd12, 6'd20, 1'b0, 1'b0);
      tick;
      tick;
      for (int c = 3; c < 7; c++) begin
         total++;
         if ({done_valid, done_tag, unit_start, req_ready} !==
             {1'b1, 6'd12, 1'b0, 2'b00}) begin
            bad++;
            $display("FAIL b2b_stall c%0d: got %b want %b", c,
                     {done_valid, done_tag, unit_start, req_ready},
                     {1'b1, 6'd12, 1'b0, 2'b00});
         end
         tick;
      end
      drive(2'b10, 2'b00, 6'd12, 6'd20, 1'b1, 1'b0);
      total++;
      if ({req_ready, unit_start, unit_sel, done_valid} !== 5'b10111) begin
         bad++;
         $display("FAIL b2b_regrant: got %b want 10111",
                  {req_ready, unit_start, unit_sel, done_valid});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      tick;
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
      total++;
      if ({done_valid, done_tag} !== {1'b1, 6'd20}) begin
         bad++;
         $display("FAIL b2b_second: got %b/%0d want 1/20",
                  done_valid, done_tag);
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
   endtask

   task automatic test_flush;
      bit saw_dv;
      drive(2'b01, 2'b01, 6'd3, 6'd0, 1'b0, 1'b0);
      total++;
      if ({unit_start, unit_is_div} !== 2'b11) begin
         bad++;
         $display("FAIL flush_start: got %b want 11", {unit_start, unit_is_div});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      repeat (14) tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      total++;
      if ({busy, done_valid} !== 2'b10) begin
         bad++;
         $display("FAIL flush_run: got %b want 10", {busy, done_valid});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL flush_idle: got busy=%b want 0", busy);
      end
      saw_dv = 1'b0;
      repeat (30) begin
         if (done_valid) saw_dv = 1'b1;
         tick;
      end
      total++;
      if (saw_dv !== 1'b0) begin
         bad++;
         $display("FAIL flush_no_done: got done_valid seen=%b want 0", saw_dv);
      end
      drive(2'b01, 2'b00, 6'd7, 6'd0, 1'b0, 1'b1);
      total++;
      if ({req_ready, unit_start} !== 3'b000) begin
         bad++;
         $display("FAIL flush_grant: got %b want 000", {req_ready, unit_start});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL flush_nogo: got busy=%b want 0", busy);
      end
      drive(2'b01, 2'b00, 6'd7, 6'd0, 1'b0, 1'b0);
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      tick;
      tick;
      total++;
      if ({done_valid, done_tag} !== {1'b1, 6'd7}) begin
         bad++;
         $display("FAIL flush_pre_done: got %b/%0d want 1/7",
                  done_valid, done_tag);
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      total++;
      if ({busy, done_valid} !== 2'b10) begin
         bad++;
         $display("FAIL flush_done: got %b want 10", {busy, done_valid});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      total++;
      if ({busy, done_valid} !== 2'b00) begin
         bad++;
         $display("FAIL flush_done_idle: got %b want 00", {busy, done_valid});
      end
   endtask

   task automatic test_async_reset;
      bit saw_dv;
      drive(2'b10, 2'b10, 6'd0, 6'd4, 1'b0, 1'b0);
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      tick;
      tick;
      #2;
      resetn = 1'b0;
      drive(2'b11, 2'b11, 6'd1, 6'd2, 1'b0, 1'b0);
      total++;
      if ({req_ready, unit_start, unit_sel, unit_is_div, done_valid,
           done_tag, busy} !== 13'd0) begin
         bad++;
         $display("FAIL arst_outputs: got %b want 0",
                  {req_ready, unit_start, unit_sel, unit_is_div,
                   done_valid, done_tag, busy});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
      resetn = 1'b1;
      saw_dv = 1'b0;
      repeat (40) begin
         if (done_valid || busy) saw_dv = 1'b1;
         tick;
      end
      total++;
      if (saw_dv !== 1'b0) begin
         bad++;
         $display("FAIL arst_no_done: got activity=%b want 0", saw_dv);
      end
      drive(2'b11, 2'b00, 6'd33, 6'd44, 1'b0, 1'b0);
      total++;
      if ({req_ready, unit_start, unit_sel} !== 4'b0110) begin
         bad++;
         $display("FAIL arst_regrant: got %b want 0110",
                  {req_ready, unit_start, unit_sel});
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      tick;
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
      total++;
      if ({done_valid, done_tag} !== {1'b1, 6'd33}) begin
         bad++;
         $display("FAIL arst_done: got %b/%0d want 1/33", done_valid, done_tag);
      end
      tick;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      int         cyc, done_at;
      bit         act, in_done, acc, e_grant, e_dv;
      logic [0:0] ptr, e_sel, i;
      logic [5:0] m_tag;
      logic [1:0] d;
      #2;
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      tick;
      cyc = 0; done_at = 0; act = 1'b0; ptr = 1'b0; m_tag = '0;
      for (int n = 0; n < 1500; n++) begin
         d = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         drive(2'($urandom_range(0, 3)), d, 6'($urandom), 6'($urandom),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
         in_done = act && (cyc >= done_at);
         acc     = !flush && (!act || (in_done && done_ack));
         e_grant = 1'b0;
         e_sel   = 1'b0;
         if (acc) begin
            for (int k = 0; k < 2; k++) begin
               i = 1'((int'(ptr) + k) % 2);
               if (!e_grant && req_valid[i]) begin
                  e_grant = 1'b1;
                  e_sel   = i;
               end
            end
         end
         e_dv = in_done && !flush;
         total++;
         if ({req_ready, unit_start, busy, done_valid} !==
             {(e_grant ? 2'(1 << e_sel) : 2'b00), e_grant, act, e_dv}) begin
            bad++;
            $display("FAIL rand_ctl n%0d: got %b want %b", n,
                     {req_ready, unit_start, busy, done_valid},
                     {(e_grant ? 2'(1 << e_sel) : 2'b00), e_grant, act, e_dv});
         end
         if (e_grant) begin
            total++;
            if ({unit_sel, unit_is_div} !== {e_sel, req_is_div[e_sel]}) begin
               bad++;
               $display("FAIL rand_sel n%0d: got %b want %b", n,
                        {unit_sel, unit_is_div}, {e_sel, req_is_div[e_sel]});
            end
         end
         if (e_dv) begin
            total++;
            if (done_tag !== m_tag) begin
               bad++;
               $display("FAIL rand_tag n%0d: got %0d want %0d", n,
                        done_tag, m_tag);
            end
         end
         if (flush) begin
            act = 1'b0;
         end else if (e_grant) begin
            act     = 1'b1;
            done_at = cyc + (req_is_div[e_sel] ? DC : MC);
            m_tag   = req_tag[e_sel];
            ptr     = RR ? (e_sel + 1'b1) : 1'b0;
         end else if (in_done && done_ack) begin
            act = 1'b0;
         end
         cyc++;
         tick;
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
   endtask

   initial begin
      resetn = 1'b0;
      drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      tick;
      test_reset;
      test_single_mult;
      test_single_div;
      test_contention;
      test_back_to_back;
      test_flush;
      test_async_reset;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Scheduler that shares the single multi-cycle multiply/divide unit between the `ISSUE_WIDTH` execute slots of the out-of-order core. It arbitrates start requests, sequences each operation through a latency counter, and presents the result tag to commit/wake-up with a hold-until-ack handshake. It sits between issue/execute (requesters) and commit (result consumer), and obeys pipeline flush from the hazard unit.

## Interface
Parameters:
- `REQ_NUM`, 2: number of requesting execute slots (≥2).
- `TAG_W`, 6: width of the physical-register / ROB tag (`preg_addr_t`).
- `MULT_CYCLES`, 3: multiply latency in cycles, grant to `done_valid` (≥2).
- `DIV_CYCLES`, 33: divide latency in cycles, grant to `done_valid` (≥2).

Ports:
- `clk` in 1: clock; single clock domain.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in REQ_NUM: slot i requests the unit.
- `req_is_div` in REQ_NUM: 1 = divide, 0 = multiply.
- `req_tag` in REQ_NUM×TAG_W: destination tag per slot.
- `req_ready` out REQ_NUM: one-hot grant; the request is consumed in the cycle it is high.
- `unit_start` out 1: start pulse to the mul/div datapath.
- `unit_is_div` out 1: operation type for the started operation.
- `unit_sel` out $clog2(REQ_NUM): operand mux select (granted slot index).
- `done_valid` out 1: result ready.
- `done_tag` out TAG_W: tag of the finished operation.
- `done_ack` in 1: commit accepts the result this cycle.
- `flush` in 1: cancel everything (hazard flushE).
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- Arbitration is combinational and occurs only when the FSM is "accepting": IDLE, or DONE with `done_ack`=1. A grant also requires `flush`=0.
  - Priority search starts at `rr_ptr` and wraps modulo REQ_NUM. The first i with `req_valid[i]` is granted.
  - On a grant: `req_ready[i]`=1, `unit_start`=1, `unit_sel`=i, `unit_is_div`=`req_is_div[i]`.
  - Registered on the grant: `tag_q` ← `req_tag[i]`, `div_q` ← `req_is_div[i]`, `cnt` ← (div ? DIV_CYCLES : MULT_CYCLES) − 1, `rr_ptr` ← (i+1) mod REQ_NUM, next state RUN.
- RUN: `cnt` decrements each cycle. When `cnt`==1, next state is DONE.
- DONE:
  - `done_valid` = !`flush`, `done_tag` = `tag_q`.
  - Holds while `done_ack`=0.
  - With `done_ack`=1: next state is RUN if a new grant occurs the same cycle, otherwise IDLE.
- `flush`=1 in any state: no grant, `done_valid`=0, and next state IDLE. `tag_q`/`cnt` are don't-care; `rr_ptr` is unchanged.
- `done_ack` while not in DONE is ignored.
- `unit_is_div`/`unit_sel` are don't-care when `unit_start`=0.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `cnt`=0, `tag_q`=0.
  - Outputs `req_ready`=0, `unit_start`=0, `done_valid`=0, `busy`=0, `done_tag`=0, `unit_sel`=0, `unit_is_div`=0.
- Grant in cycle T produces `done_valid` first high in cycle T+L, where L = MULT_CYCLES or DIV_CYCLES.
- Back-to-back: with `done_ack` in cycle T+L and a pending request, the next grant occurs in T+L, giving a throughput of one operation per L cycles.
- Reset asserted mid-operation aborts immediately, and no `done_valid` follows.
- A flush in the grant cycle suppresses the grant entirely; `req_ready` stays 0.

## Configuration
- `MULDIV_RR_EN` defined: round-robin priority via `rr_ptr` as above.
- `MULDIV_RR_EN` undefined: fixed priority, lowest index wins. `rr_ptr` is removed, which is equivalent to it being held at 0.

## Test plan
- Single mult: slot0 requests with tag 5 at cycle 10 → `req_ready`=01 and `unit_start` at 10; `done_valid` with tag 5 at cycle 13; ack at 13 → IDLE at 14.
- Single div: slot1 requests with tag 9 at cycle 0 → `unit_sel`=1, `unit_is_div`=1; `done_valid` at cycle 33, held until ack at 40; `busy`=0 at 41.
- Contention (RR_EN): both slots request continuously (mult) with immediate ack → grants alternate 0,1,0,1 at cycles 0,3,6,9. Without the macro, all grants go to slot0.
- Ack stall + back-to-back: `done_ack` low for 4 cycles → `done_tag` stable and no new `unit_start`. Ack with slot1 pending → `req_ready`=10 in the same cycle.
- Flush: flush at cycle 15 of a divide started at 0 → IDLE at 16 and no `done_valid`. Flush coincident with a request → no grant. Flush in DONE → `done_valid`=0 that cycle.
- Async reset: assert `resetn`=0 mid-RUN, off-edge → all outputs 0 immediately; the next request after release is granted normally to slot0.
